// File: rtl/scale_ramp_gen_pkg.sv
// scale_ramp_gen_pkg: shared widths, FSM states and ramp config layout for the scale ramp generator
package scale_ramp_gen_pkg;
  localparam int SCALE_W = 18;
  localparam int SCALE_FRAC = 16;
  localparam int INTERVAL_W = 16;
  localparam int CFG_W = INTERVAL_W + 2 * SCALE_W;
  typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_e;
  typedef struct packed {
    logic [INTERVAL_W-1:0]    interval;
    logic signed [SCALE_W-1:0] delta;
    logic signed [SCALE_W-1:0] target;
  } ramp_cfg_t;
endpackage

// File: rtl/axis_if.sv
// Axis_If: minimal valid/ready/data stream with master and slave views
interface Axis_If #(parameter int W = 8) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  modport Master_Simple (output valid, output data, input ready);
  modport Slave_Simple (input valid, input data, output ready);
endinterface

// File: rtl/scale_ramp_gen.sv
// scale_ramp_gen: steps a signed 2Q16 scale toward a configured target, one step per interval, clamped at target
module scale_ramp_gen
  import scale_ramp_gen_pkg::*;
#(
  parameter int SCALE_WIDTH     = 18,
  parameter int SCALE_FRAC_BITS = 16,
  parameter int INTERVAL_WIDTH  = 16,
  parameter int RESET_SCALE     = 1 << SCALE_FRAC_BITS
) (
  input  logic         clk,
  input  logic         reset,
  Axis_If.Slave_Simple  ramp_cfg,
  Axis_If.Master_Simple scale_factor,
  output logic         busy
);
  localparam int SW = SCALE_WIDTH;
  localparam int IW = INTERVAL_WIDTH;
  logic [IW-1:0]        cfg_interval, cfg_load;
  logic signed [SW-1:0] cfg_delta, cfg_target;
  state_e               state_q, state_d;
  logic signed [SW-1:0] cur_q, cur_d, target_q, target_d, delta_q, delta_d;
  logic [IW-1:0]        interval_q, interval_d, cnt_q, cnt_d;
  logic                 final_q, final_d;
  logic                 accept, jump, clamp, cfg_pos, cfg_neg;
  logic signed [SW:0]   sum, target_x;
  assign {cfg_interval, cfg_delta, cfg_target} = ramp_cfg.data;
  assign accept   = ramp_cfg.valid && ramp_cfg.ready;
  assign cfg_load = (cfg_interval == '0) ? IW'(1) : cfg_interval;
  assign cfg_neg  = cfg_delta[SW-1];
  assign cfg_pos  = !cfg_delta[SW-1] && (cfg_delta != '0);
  // Jump straight to target unless delta is nonzero and actually points toward it
  assign jump     = !((cfg_pos && cfg_target > cur_q) || (cfg_neg && cfg_target < cur_q));
  assign sum      = {cur_q[SW-1], cur_q} + {delta_q[SW-1], delta_q};
  assign target_x = {target_q[SW-1], target_q};
  assign clamp    = delta_q[SW-1] ? (sum <= target_x) : (sum >= target_x);
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    target_d   = target_q;
    delta_d    = delta_q;
    interval_d = interval_q;
    cnt_d      = cnt_q;
    final_d    = final_q;
    if (accept) begin
      target_d   = cfg_target;
      delta_d    = cfg_delta;
      interval_d = cfg_load;
      cnt_d      = cfg_load;
      final_d    = jump;
      cur_d      = jump ? cfg_target : cur_q;
      state_d    = jump ? EMIT : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - IW'(1);
      if (cnt_q == IW'(1)) begin
        cur_d   = clamp ? target_q : sum[SW-1:0];
        final_d = clamp;
        state_d = EMIT;
      end
    end else if (state_q == EMIT && scale_factor.ready) begin
      state_d = final_q ? IDLE : WAIT;
      cnt_d   = interval_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= SW'(RESET_SCALE);
      target_q   <= '0;
      delta_q    <= '0;
      interval_q <= '0;
      cnt_q      <= '0;
      final_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      target_q   <= target_d;
      delta_q    <= delta_d;
      interval_q <= interval_d;
      cnt_q      <= cnt_d;
      final_q    <= final_d;
    end
  end
  assign ramp_cfg.ready     = state_q != EMIT;
  assign scale_factor.valid = state_q == EMIT;
  assign scale_factor.data  = cur_q;
  assign busy               = state_q != IDLE;
endmodule

// File: tb/tb_scale_ramp_gen.sv
// tb_scale_ramp_gen: directed ramp scenarios with a cycle-stamped scoreboard of expected outputs
module tb_scale_ramp_gen;
  import scale_ramp_gen_pkg::*;
  typedef struct { int cyc; int data; } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  Axis_If #(.W(CFG_W))   cfg_if ();
  Axis_If #(.W(SCALE_W)) sf_if ();
  scale_ramp_gen dut (
    .clk          (clk),
    .reset        (reset),
    .ramp_cfg     (cfg_if),
    .scale_factor (sf_if),
    .busy         (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end
  always @(negedge clk) begin
    if (!reset && sf_if.valid && sf_if.ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out observed=%0d at cyc %0d expected no output", sf_if.data, cyc);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks += 2;
        assert (int'(sf_if.data) === e.data) else begin
          errors++;
          $error("FAIL out_data observed=%0d expected=%0d", sf_if.data, e.data);
        end
        assert (cyc === e.cyc) else begin
          errors++;
          $error("FAIL out_cycle observed=%0d expected=%0d data=%0d", cyc, e.cyc, e.data);
        end
      end
    end
  end
  function automatic ramp_cfg_t mk(int tgt, int dlt, int itv);
    ramp_cfg_t c;
    c.target   = SCALE_W'(tgt);
    c.delta    = SCALE_W'(dlt);
    c.interval = INTERVAL_W'(itv);
    return c;
  endfunction
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step_to(int c);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (cyc < c && k < 1000);
  endtask
  task automatic push(int c, int d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    sb.push_back(e);
  endtask
  task automatic send(int tgt, int dlt, int itv, output int t);
    t = cyc;
    chk("cfg_ready_at_send", int'(cfg_if.ready), 1);
    cfg_if.valid = 1'b1;
    cfg_if.data  = mk(tgt, dlt, itv);
    step_to(t + 1);
    cfg_if.valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step_to(cyc + 2);
    reset = 1'b0;
    step_to(cyc + 1);
    chk("rst_valid", int'(sf_if.valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_ready", int'(cfg_if.ready), 1);
    chk("rst_cur", int'(sf_if.data), 65536);
  endtask
  initial begin
    int t, t2;
    cfg_if.valid = 1'b0;
    cfg_if.data  = '0;
    sf_if.ready  = 1'b1;
    #1;
    do_reset();
    send(98304, 16384, 4, t);
    push(t + 5, 81920);
    push(t + 10, 98304);
    chk("up_busy_wait", int'(busy), 1);
    chk("up_valid_wait", int'(sf_if.valid), 0);
    step_to(t + 11);
    chk("up_busy_done", int'(busy), 0);
    do_reset();
    send(70000, 16384, 2, t);
    push(t + 3, 70000);
    step_to(t + 4);
    chk("clamp_busy_done", int'(busy), 0);
    do_reset();
    send(32768, 100, 5, t);
    push(t + 1, 32768);
    step_to(t + 2);
    send(40000, 0, 3, t);
    push(t + 1, 40000);
    step_to(t + 2);
    send(50000, 4000, 0, t);
    push(t + 2, 44000);
    push(t + 4, 48000);
    push(t + 6, 50000);
    step_to(t + 7);
    chk("itv0_busy_done", int'(busy), 0);
    send(60000, 5000, 3, t);
    sf_if.ready = 1'b0;
    for (int c = t + 4; c <= t + 10; c++) begin
      step_to(c);
      chk("bp_valid", int'(sf_if.valid), 1);
      chk("bp_data", int'(sf_if.data), 55000);
      chk("bp_cfg_ready", int'(cfg_if.ready), 0);
    end
    step_to(t + 11);
    sf_if.ready = 1'b1;
    push(t + 11, 55000);
    push(t + 15, 60000);
    step_to(t + 16);
    chk("bp_busy_done", int'(busy), 0);
    do_reset();
    send(98304, 16384, 4, t);
    push(t + 5, 81920);
    step_to(t + 7);
    send(65536, -8192, 1, t2);
    push(t2 + 2, 73728);
    push(t2 + 4, 65536);
    step_to(t2 + 5);
    chk("retarget_busy_done", int'(busy), 0);
    chk("retarget_cur", int'(sf_if.data), 65536);
    do_reset();
    send(98304, 16384, 4, t);
    step_to(t + 2);
    reset = 1'b1;
    cfg_if.valid = 1'b1;
    cfg_if.data  = mk(12345, 0, 0);
    step_to(t + 3);
    chk("midrst_valid", int'(sf_if.valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cur", int'(sf_if.data), 65536);
    reset = 1'b0;
    cfg_if.valid = 1'b0;
    step_to(t + 4);
    chk("midrst_idle", int'(busy), 0);
    send(30000, 100, 2, t);
    push(t + 1, 30000);
    step_to(t + 3);
    chk("jump_busy_done", int'(busy), 0);
    step_to(cyc + 5);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scale_ramp_gen.md
SCALE_RAMP_GEN -- requirements
Module: scale_ramp_gen

Interface
REQ-001 SHALL have parameters, one per line:
- SCALE_WIDTH, 18, signed scale word width (2Q16)
- SCALE_FRAC_BITS, 16, fractional bits of scale word
- INTERVAL_WIDTH, 16, unsigned step-interval field width
- RESET_SCALE, 1<<SCALE_FRAC_BITS, scale value after reset (unity gain)
REQ-002 SHALL have ports, one per line:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- ramp_cfg  Axis_If.Slave_Simple  INTERVAL_WIDTH+2*SCALE_WIDTH  {interval, delta, target}, target in LSBs
- scale_factor  Axis_If.Master_Simple  SCALE_WIDTH  signed 2Q16 scale stream to the DAC prescaler
- busy  output  1  high whenever state is not IDLE
REQ-003 SHALL treat target and delta as signed 2Q16 and interval as unsigned cycles; an interval of 0 SHALL behave as 1.

Function
REQ-004 SHALL implement states IDLE, WAIT, EMIT; register cur holds the last scale value computed.
REQ-005 ramp_cfg.ready SHALL be 1 in IDLE and WAIT, and 0 in EMIT.
REQ-006 On config accept (valid && ready), SHALL latch target, delta and interval, and load counter=max(interval,1).
REQ-007 On accept, if delta==0, or cur==target, or sign(delta) points away from target: cur<=target, final<=1, next state EMIT (output valid one cycle after accept).
REQ-008 Otherwise, on accept, next state WAIT with final<=0; an accept while in WAIT SHALL retarget from the current cur and restart the counter.
REQ-009 In WAIT, counter SHALL decrement each cycle; in the cycle counter==1, SHALL set cur<=cur+delta, computed in SCALE_WIDTH+1 bits, and go to EMIT.
REQ-010 Clamp: if delta>0 and sum>=target, or delta<0 and sum<=target, SHALL set cur<=target and final<=1. Because the clamp keeps cur within the range of target, no other saturation is needed.
REQ-011 In EMIT, scale_factor.valid SHALL be 1 and data SHALL be cur, held stable until ready.
REQ-012 On an EMIT handshake: if final, go to IDLE; else go to WAIT with counter reloaded.
REQ-013 Cadence:
- ramp with interval N, accept at cycle T: first valid at T+N+1.
- with ready held high, subsequent valids every N+1 cycles.
REQ-014 Each computed step SHALL be emitted exactly once (no drops, no duplicates), regardless of backpressure duration.
REQ-015 In IDLE, scale_factor.valid SHALL be 0 and cur SHALL remain unchanged.

Reset
REQ-016 Reset SHALL set state=IDLE, cur=RESET_SCALE, counter=0, final=0, scale_factor.valid=0, busy=0, ramp_cfg.ready=1 (IDLE value).
REQ-017 Reset mid-ramp or mid-EMIT SHALL abandon the ramp with no further output; the next config ramps from RESET_SCALE.
REQ-018 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-019 A shared package SHALL hold the config struct typedef (interval, delta, target), the state enum, and the width constants.
REQ-020 No sub-module is required; one always_ff FSM plus combinational next-value and clamp logic suffices.

Verification
REQ-021 Unity ramp-up: cur=65536; cfg target=98304, delta=16384, interval=4 accepted at T; ready high -> outputs 81920 at T+5 and 98304 at T+10; busy low from T+11.
REQ-022 Overshoot clamp: cur=65536; cfg target=70000, delta=16384, interval=2 -> single output 70000 at T+3, then IDLE.
REQ-023 Wrong-sign delta: cur=65536; cfg target=32768, delta=+100 -> immediate jump, output 32768 at T+1; delta=0 behaves identically.
REQ-024 Backpressure: ready low for 7 cycles during EMIT -> valid and data stay stable; cfg.ready stays 0; no step is lost or duplicated.
REQ-025 Retarget in WAIT: during the ramp of REQ-021, new cfg target=65536, delta=-8192, interval=1 accepted while in WAIT -> descending outputs from the current cur down to 65536, spaced per REQ-013.
REQ-026 Reset mid-ramp: assert reset in WAIT -> valid=0 and busy=0 next cycle; cur=65536; a subsequent jump config outputs its target at T+1.
